// File: rtl/riscv_mem_responder_pkg.sv
// Shared definitions for the RV32 memory responder: loader state encoding,
// the canonical NOP word and byte-lane positions used by the program loader.
package riscv_mem_responder_pkg;

  typedef enum logic [1:0] {
    LD_LEN  = 2'd0,
    LD_DATA = 2'd1,
    LD_RUN  = 2'd2
  } ld_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

  localparam int BYTE_W = 8;

  // Little-endian lane positions within a 32-bit word
  localparam logic [1:0] BYTE_LANE_0 = 2'd0;
  localparam logic [1:0] BYTE_LANE_1 = 2'd1;
  localparam logic [1:0] BYTE_LANE_2 = 2'd2;
  localparam logic [1:0] BYTE_LANE_3 = 2'd3;

endpackage

// File: rtl/riscv_mem_responder_byte_word_assembler.sv
// 8-to-32 little-endian packer: collects three bytes, then emits the full word
// combinationally together with the fourth byte so it can be written that cycle.
module byte_word_assembler
  import riscv_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_vld,
  output logic [31:0]       word
);

  logic [1:0]  byte_cnt;
  logic [23:0] lo_bytes;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= BYTE_LANE_0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Lower lanes are data only; a stale value is harmless because the
  // counter decides when a word is complete.
  always_ff @(posedge clk) begin
    if (byte_vld) begin
      case (byte_cnt)
        BYTE_LANE_0: lo_bytes[7:0]   <= byte_data;
        BYTE_LANE_1: lo_bytes[15:8]  <= byte_data;
        BYTE_LANE_2: lo_bytes[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

  assign word_vld = byte_vld && (byte_cnt == BYTE_LANE_3);
  assign word     = {byte_data, lo_bytes};

endmodule

// File: rtl/riscv_mem_responder.sv
// Unified instruction/data RAM for the pipelined RV32 core, filled after reset
// by a byte-stream loader; the core is held in reset until the image is in.
module riscv_mem_responder
  import riscv_mem_responder_pkg::*;
#(
  parameter int                       WORD_BITWIDTH = 32,
  parameter int                       MEM_ADDR_BITS = 10,
  parameter logic [WORD_BITWIDTH-1:0] NOP_INST      = NOP_ENCODING
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_ce_i,
  input  logic [WORD_BITWIDTH-1:0] inst_addr_i,
  output logic [WORD_BITWIDTH-1:0] inst_o,
  input  logic                     data_ce_i,
  input  logic                     data_we_i,
  input  logic [WORD_BITWIDTH-1:0] data_addr_i,
  input  logic [WORD_BITWIDTH-1:0] data_i,
  output logic [WORD_BITWIDTH-1:0] data_o,
  input  logic                     ld_valid_i,
  input  logic [BYTE_W-1:0]        ld_data_i,
  output logic                     ld_ready_o,
  output logic                     core_rst_o,
  output logic                     load_done_o,
  output logic                     err_o
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  ld_state_t state, state_nxt;

  logic                     run;
  logic                     ld_accept;
  logic                     asm_word_vld;
  logic [31:0]              asm_word;
  logic [WORD_BITWIDTH-1:0] n_words;
  logic [WORD_BITWIDTH-1:0] ld_ptr;
  logic                     ld_ptr_oor;
  logic                     ld_last_word;
  logic                     ld_wr_en;

  logic [MEM_ADDR_BITS-1:0] i_idx, d_idx;
  logic                     i_oor, i_mis, d_oor, d_mis;
  logic                     core_fetch, core_load, core_store, core_wr_en;
  logic                     err_set;

  logic                     wr_en;
  logic [MEM_ADDR_BITS-1:0] wr_idx;
  logic [WORD_BITWIDTH-1:0] wr_data;

  logic [WORD_BITWIDTH-1:0] mem [DEPTH];

  assign run        = (state == LD_RUN);
  assign ld_ready_o = !run;
  assign ld_accept  = ld_valid_i && ld_ready_o;

  byte_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (run),
    .byte_vld  (ld_accept),
    .byte_data (ld_data_i),
    .word_vld  (asm_word_vld),
    .word      (asm_word)
  );

  assign ld_ptr_oor   = |ld_ptr[WORD_BITWIDTH-1:MEM_ADDR_BITS];
  assign ld_last_word = (ld_ptr == n_words - 1'b1);

  always_comb begin
    state_nxt = state;
    ld_wr_en  = 1'b0;
    case (state)
      LD_LEN: begin
        if (asm_word_vld) state_nxt = (asm_word == '0) ? LD_RUN : LD_DATA;
      end
      LD_DATA: begin
        if (asm_word_vld) begin
          ld_wr_en = !ld_ptr_oor;
          if (ld_last_word) state_nxt = LD_RUN;
        end
      end
      LD_RUN: ;
      default: state_nxt = LD_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LD_LEN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_words <= '0;
      ld_ptr  <= '0;
    end else if (asm_word_vld) begin
      if (state == LD_LEN) begin
        n_words <= asm_word;
        ld_ptr  <= '0;
      end else if (state == LD_DATA) begin
        ld_ptr <= ld_ptr + 1'b1;
      end
    end
  end

  // Core-side address decode; low address bits only feed the alignment check
  assign i_idx = inst_addr_i[MEM_ADDR_BITS+1:2];
  assign i_oor = |inst_addr_i[WORD_BITWIDTH-1:MEM_ADDR_BITS+2];
  assign i_mis = |inst_addr_i[1:0];
  assign d_idx = data_addr_i[MEM_ADDR_BITS+1:2];
  assign d_oor = |data_addr_i[WORD_BITWIDTH-1:MEM_ADDR_BITS+2];
  assign d_mis = |data_addr_i[1:0];

  assign core_fetch = run && inst_ce_i;
  assign core_load  = run && data_ce_i && !data_we_i;
  assign core_store = run && data_ce_i && data_we_i;
  assign core_wr_en = core_store && !d_oor;

  assign inst_o = (core_fetch && !i_oor) ? mem[i_idx] : NOP_INST;
  assign data_o = core_load ? mem[d_idx] : '0;

  assign err_set = (core_fetch && (i_oor || i_mis))
                || (run && data_ce_i && d_mis)
                || (core_store && d_oor)
                || ((state == LD_DATA) && asm_word_vld && ld_ptr_oor);

  // Loader and core never write in the same state, so the mux follows run
  always_comb begin
    wr_en   = ld_wr_en || core_wr_en;
    wr_idx  = run ? d_idx  : ld_ptr[MEM_ADDR_BITS-1:0];
    wr_data = run ? data_i : asm_word;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_o       <= 1'b0;
      core_rst_o  <= 1'b1;
      load_done_o <= 1'b0;
    end else begin
      err_o       <= err_o || err_set;
      core_rst_o  <= !run;
      load_done_o <= run && core_rst_o;
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench for riscv_mem_responder: loader images, core loads/stores,
// error flagging and reset in the middle of a load.
module tb_riscv_mem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_ready_o;
  logic        core_rst_o;
  logic        load_done_o;
  logic        err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .inst_ce_i   (inst_ce_i),
    .inst_addr_i (inst_addr_i),
    .inst_o      (inst_o),
    .data_ce_i   (data_ce_i),
    .data_we_i   (data_we_i),
    .data_addr_i (data_addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .ld_valid_i  (ld_valid_i),
    .ld_data_i   (ld_data_i),
    .ld_ready_o  (ld_ready_o),
    .core_rst_o  (core_rst_o),
    .load_done_o (load_done_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid_i = 1'b1;
    ld_data_i  = b;
    tick();
    ld_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic fetch(input logic [31:0] a);
    inst_ce_i   = 1'b1;
    inst_addr_i = a;
    #1;
  endtask

  task automatic load(input logic [31:0] a);
    data_ce_i   = 1'b1;
    data_we_i   = 1'b0;
    data_addr_i = a;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    data_ce_i   = 1'b1;
    data_we_i   = 1'b1;
    data_addr_i = a;
    data_i      = d;
    tick();
    data_ce_i   = 1'b0;
    data_we_i   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_ce_i = 1'b0; inst_addr_i = '0;
    data_ce_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_i = '0;
    ld_valid_i = 1'b0; ld_data_i = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_core_rst", 32'(core_rst_o), 32'd1);
    chk("rst_ready", 32'(ld_ready_o), 32'd1);
    chk("rst_done", 32'(load_done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    fetch(32'h0);
    chk("rst_inst_nop", inst_o, NOP);
    inst_ce_i = 1'b0;
    rst = 1'b0;

    // Image with two words
    send_word(32'd2);
    chk("len_core_rst", 32'(core_rst_o), 32'd1);
    send_word(32'h00A0_0513);
    send_word(32'h00B0_0593);
    chk("img1_ready_off", 32'(ld_ready_o), 32'd0);
    chk("img1_core_rst_hold", 32'(core_rst_o), 32'd1);
    chk("img1_done_early", 32'(load_done_o), 32'd0);
    tick();
    chk("img1_core_rst_fall", 32'(core_rst_o), 32'd0);
    chk("img1_done_pulse", 32'(load_done_o), 32'd1);
    tick();
    chk("img1_done_once", 32'(load_done_o), 32'd0);
    chk("img1_ready_run", 32'(ld_ready_o), 32'd0);
    fetch(32'h0);
    chk("img1_ram0", inst_o, 32'h00A0_0513);
    load(32'h4);
    chk("img1_ram1", data_o, 32'h00B0_0593);
    data_ce_i = 1'b0;
    chk("img1_err", 32'(err_o), 32'd0);

    // Store with same-cycle fetch of the same word
    store(32'h40, 32'h1111_1111);
    data_ce_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h40; data_i = 32'hDEAD_BEEF;
    fetch(32'h40);
    chk("st_old_value", inst_o, 32'h1111_1111);
    chk("st_data_o_zero", data_o, 32'h0);
    tick();
    load(32'h40);
    chk("st_new_load", data_o, 32'hDEAD_BEEF);
    chk("st_new_fetch", inst_o, 32'hDEAD_BEEF);
    inst_ce_i = 1'b0;
    #1;
    chk("inst_ce_off", inst_o, NOP);
    data_ce_i = 1'b0;
    #1;
    chk("data_ce_off", data_o, 32'h0);
    chk("st_err", 32'(err_o), 32'd0);

    // Misaligned store proceeds on the word index
    store(32'h42, 32'h1234_5678);
    chk("mis_err", 32'(err_o), 32'd1);
    load(32'h40);
    chk("mis_written", data_o, 32'h1234_5678);
    data_ce_i = 1'b0;

    // Reset, stores dropped outside RUN, empty image
    fetch(32'h0);
    rst = 1'b1;
    tick();
    chk("rst2_core_rst", 32'(core_rst_o), 32'd1);
    chk("rst2_err_clr", 32'(err_o), 32'd0);
    chk("rst2_ready", 32'(ld_ready_o), 32'd1);
    chk("rst2_inst_nop", inst_o, NOP);
    rst = 1'b0;
    load(32'h40);
    chk("len_load_zero", data_o, 32'h0);
    store(32'h40, 32'h0);
    inst_ce_i = 1'b0;
    send_word(32'd0);
    chk("img0_ready_off", 32'(ld_ready_o), 32'd0);
    tick();
    chk("img0_core_rst", 32'(core_rst_o), 32'd0);
    chk("img0_done", 32'(load_done_o), 32'd1);
    fetch(32'h0);
    chk("img0_ram0_kept", inst_o, 32'h00A0_0513);
    load(32'h40);
    chk("len_store_dropped", data_o, 32'h1234_5678);
    data_ce_i = 1'b0;
    chk("img0_err", 32'(err_o), 32'd0);

    // Out-of-range fetch and store
    fetch(32'h0000_1000);
    chk("oor_fetch_nop", inst_o, NOP);
    tick();
    chk("oor_fetch_err", 32'(err_o), 32'd1);
    inst_ce_i = 1'b0;
    repeat (3) tick();
    chk("err_sticky", 32'(err_o), 32'd1);
    store(32'h0000_1000, 32'hCAFE_F00D);
    fetch(32'h0);
    chk("oor_store_dropped", inst_o, 32'h00A0_0513);
    inst_ce_i = 1'b0;

    // Reset after two bytes of a data word, then a fresh image
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_word(32'd3);
    send_word(32'h1234_5678);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    tick();
    chk("mid_core_rst", 32'(core_rst_o), 32'd1);
    chk("mid_ready", 32'(ld_ready_o), 32'd1);
    chk("mid_err_clr", 32'(err_o), 32'd0);
    rst = 1'b0;
    send_word(32'd1);
    send_word(32'h89AB_CDEF);
    tick();
    chk("img2_core_rst", 32'(core_rst_o), 32'd0);
    chk("img2_done", 32'(load_done_o), 32'd1);
    fetch(32'h0);
    chk("img2_ram0", inst_o, 32'h89AB_CDEF);
    fetch(32'h4);
    chk("img2_ram1_kept", inst_o, 32'h00B0_0593);
    load(32'h40);
    chk("img2_ram10_kept", data_o, 32'h1234_5678);
    chk("img2_err", 32'(err_o), 32'd0);
    inst_ce_i = 1'b0;
    data_ce_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
